game_tick_sync: RTL and testbench

//  Receiving end of the slow-rate clock divider: takes its free-running 2/4/8 Hz level

---
 rtl/game_tick_sync.sv | 120 ++++++++++++
 tb/tb_game_tick_sync.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_sync.sv
// Turns the slow divider's 2/4/8 Hz level outputs into single-cycle clk-domain enables,
// and runs the game-pacing FSM that decides when the snake moves and counts its moves.
module game_tick_sync #(
    parameter int STEP_W   = 16,
    parameter int SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_2Hz,
    input  logic              clk_4Hz,
    input  logic              clk_8Hz,
    input  logic [1:0]        speed_sel,
    input  logic              start,
    input  logic              pause,
    input  logic              game_over,
    output logic              move_tick,
    output logic              blink_tick,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] step_cnt,
    output logic              step_wrap
);

    // start/pause/game_over are one-cycle pulses acted on at the clk edge that samples them;
    // move_tick/blink_tick/step_wrap are one-cycle enables, never clocks.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t                     state_q;
    logic [2:0][SYNC_LEN-1:0]   sync_q;
    logic [2:0]                 prev_q;
    logic [2:0]                 rate_in;
    logic [2:0]                 sync_out;
    logic [2:0]                 rise;
    logic [1:0]                 active_sel;
    logic                       sel_rise;
    logic                       fire;

    always_comb begin
        rate_in = {clk_8Hz, clk_4Hz, clk_2Hz};
        for (int i = 0; i < 3; i++) begin
            sync_out[i] = sync_q[i][SYNC_LEN-1];
        end
        rise = sync_out & ~prev_q;
        // Code 3 is reserved and runs at the 8 Hz rate.
        case (active_sel)
            2'd0:    sel_rise = rise[0];
            2'd1:    sel_rise = rise[1];
            default: sel_rise = rise[2];
        endcase
        fire = (state_q == S_RUN) && sel_rise && !game_over && !pause;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            move_tick  <= 1'b0;
            blink_tick <= 1'b0;
            step_wrap  <= 1'b0;
            step_cnt   <= '0;
            active_sel <= 2'd0;
            state_q    <= S_IDLE;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_LEN-2:0], rate_in[i]};
            end
            prev_q     <= sync_out;
            move_tick  <= fire;
            blink_tick <= rise[0];
            step_wrap  <= 1'b0;
            if (move_tick) begin
                step_cnt  <= step_cnt + STEP_W'(1);
                step_wrap <= &step_cnt;
            end
            // Re-latching the rate only at a move keeps a speed change from splitting a period.
            if (fire) begin
                active_sel <= speed_sel;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        step_cnt   <= '0;
                        active_sel <= speed_sel;
                    end
                end
                S_RUN: begin
                    if (game_over) begin
                        state_q <= S_OVER;
                    end else if (pause) begin
                        state_q <= S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (game_over) begin
                        state_q <= S_OVER;
                    end else if (pause || start) begin
                        state_q    <= S_RUN;
                        active_sel <= speed_sel;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        step_cnt   <= '0;
                        active_sel <= speed_sel;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_tick_sync.sv
// Bench for game_tick_sync: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the pacing rules.
module tb_game_tick_sync;

    localparam int STEP_W = 4;
    localparam int SL     = 2;
    localparam int CMAX   = (1 << STEP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              r2 = 1'b0, r4 = 1'b0, r8 = 1'b0;
    logic [1:0]        speed_sel = 2'd0;
    logic              start = 1'b0, pause = 1'b0, game_over = 1'b0;
    logic              move_tick, blink_tick, step_wrap;
    logic [1:0]        state;
    logic [STEP_W-1:0] step_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    game_tick_sync #(.STEP_W(STEP_W), .SYNC_LEN(SL)) dut (
        .clk(clk), .rst(rst),
        .clk_2Hz(r2), .clk_4Hz(r4), .clk_8Hz(r8),
        .speed_sel(speed_sel), .start(start), .pause(pause), .game_over(game_over),
        .move_tick(move_tick), .blink_tick(blink_tick), .state(state),
        .step_cnt(step_cnt), .step_wrap(step_wrap)
    );

    // Behavioural model: h holds the sampled history of each rate input (bit 0 newest);
    // a rising edge is seen SL samples late, exactly as the synchroniser delays it.
    typedef struct {
        int               st;
        int               sel;
        int               cnt;
        bit               move;
        bit               blink;
        bit               wrap;
        logic [2:0][7:0]  h;
    } model_t;

    model_t mdl;

    function automatic model_t model_step(model_t m, logic r, logic [2:0] rin, logic [1:0] ss,
                                          logic st, logic pa, logic go);
        model_t     n;
        logic [2:0] rise;
        int         rate;
        bit         fire;
        n = m;
        if (r) begin
            n.st = 0; n.sel = 0; n.cnt = 0;
            n.move = 0; n.blink = 0; n.wrap = 0; n.h = '0;
            return n;
        end
        for (int i = 0; i < 3; i++) rise[i] = m.h[i][SL-1] & ~m.h[i][SL];
        rate = (m.sel == 0) ? 0 : (m.sel == 1) ? 1 : 2;
        fire = (m.st == 1) && rise[rate] && !go && !pa;
        n.wrap = m.move && (m.cnt == CMAX);
        if (m.move) n.cnt = (m.cnt + 1) % (CMAX + 1);
        if (fire) n.sel = int'(ss);
        case (m.st)
            0: if (st) begin n.st = 1; n.cnt = 0; n.sel = int'(ss); end
            1: if (go) n.st = 3; else if (pa) n.st = 2;
            2: if (go) n.st = 3; else if (pa || st) begin n.st = 1; n.sel = int'(ss); end
            3: if (st) begin n.st = 1; n.cnt = 0; n.sel = int'(ss); end
            default: ;
        endcase
        n.move  = fire;
        n.blink = rise[0];
        for (int i = 0; i < 3; i++) n.h[i] = {m.h[i][6:0], rin[i]};
        return n;
    endfunction

    always @(posedge clk) begin
        mdl <= model_step(mdl, rst, {r8, r4, r2}, speed_sel, start, pause, game_over);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cmp_move_tick",  int'(move_tick),  int'(mdl.move));
        check("cmp_blink_tick", int'(blink_tick), int'(mdl.blink));
        check("cmp_step_wrap",  int'(step_wrap),  int'(mdl.wrap));
        check("cmp_state",      int'(state),      mdl.st);
        check("cmp_step_cnt",   int'(step_cnt),   mdl.cnt);
    end

    task automatic set_rate(input int idx, input logic v);
        case (idx)
            0: r2 = v;
            1: r4 = v;
            default: r8 = v;
        endcase
    endtask

    task automatic pulse_rate(input int idx, output int moves, output int blinks, output int wraps);
        moves = 0; blinks = 0; wraps = 0;
        set_rate(idx, 1'b1);
        repeat (6) begin
            @(negedge clk);
            moves += int'(move_tick); blinks += int'(blink_tick); wraps += int'(step_wrap);
        end
        set_rate(idx, 1'b0);
        repeat (4) begin
            @(negedge clk);
            moves += int'(move_tick); blinks += int'(blink_tick); wraps += int'(step_wrap);
        end
    endtask

    task automatic do_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1; @(negedge clk); pause = 1'b0;
    endtask

    initial begin
        int m, b, w, tm, tw;

        // T1: reset held while the rate inputs toggle
        repeat (3) begin
            r2 = 1'($urandom); r4 = 1'($urandom); r8 = 1'($urandom);
            @(negedge clk);
            check("t1_state", int'(state), 0);
            check("t1_move", int'(move_tick), 0);
            check("t1_blink", int'(blink_tick), 0);
            check("t1_step_cnt", int'(step_cnt), 0);
        end
        r2 = 1'b1; r4 = 1'b1; r8 = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_move_after_rst", int'(move_tick), 0);
        check("t1_blink_after_rst", int'(blink_tick), 0);
        r2 = 1'b0; r4 = 1'b0; r8 = 1'b0;
        repeat (6) @(negedge clk);

        // T2: latency of a 4 Hz edge into move_tick
        speed_sel = 2'd1;
        do_start();
        check("t2_state_run", int'(state), 1);
        repeat (3) @(negedge clk);
        r4 = 1'b1;
        @(negedge clk); check("t2_move_k", int'(move_tick), 0);
        @(negedge clk); check("t2_move_k1", int'(move_tick), 0);
        @(negedge clk); check("t2_move_k2", int'(move_tick), 1);
        check("t2_cnt_k2", int'(step_cnt), 0);
        @(negedge clk); check("t2_move_k3", int'(move_tick), 0);
        check("t2_cnt_k3", int'(step_cnt), 1);
        check("t2_model_cnt", mdl.cnt, 1);
        tm = 0;
        repeat (100) begin @(negedge clk); tm += int'(move_tick); end
        check("t2_hold_high_moves", tm, 0);
        r4 = 1'b0;
        repeat (4) @(negedge clk);

        // T3: speed change mid-period takes effect only after the next move
        speed_sel = 2'd0;
        do_pause();
        @(negedge clk);
        do_pause();
        check("t3_state_run", int'(state), 1);
        speed_sel = 2'd2;
        pulse_rate(2, m, b, w); check("t3_8hz_before", m, 0);
        pulse_rate(0, m, b, w); check("t3_2hz_move", m, 1); check("t3_2hz_blink", b, 1);
        pulse_rate(0, m, b, w); check("t3_2hz_after", m, 0);
        pulse_rate(2, m, b, w); check("t3_8hz_after", m, 1);
        check("t3_cnt", int'(step_cnt), 3);

        // T4: paused game discards edges but keeps blinking
        do_pause();
        check("t4_state_paused", int'(state), 2);
        tm = 0; tw = 0;
        foreach (m_order[i]) begin
            pulse_rate(m_order[i], m, b, w);
            tm += m; tw += b;
        end
        check("t4_moves", tm, 0);
        check("t4_blinks", tw, 2);
        do_pause();
        check("t4_state_run", int'(state), 1);
        check("t4_cnt_kept", int'(step_cnt), 3);

        // T5: pause and game_over together on the cycle an 8 Hz edge is decided
        r8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pause = 1'b1; game_over = 1'b1;
        @(negedge clk);
        pause = 1'b0; game_over = 1'b0;
        check("t5_state_over", int'(state), 3);
        check("t5_move", int'(move_tick), 0);
        r8 = 1'b0;
        repeat (4) @(negedge clk);
        do_start();
        check("t5_state_run", int'(state), 1);
        check("t5_cnt_clear", int'(step_cnt), 0);

        // T6: 4-bit counter wraps on the 16th move
        tm = 0; tw = 0;
        repeat (15) begin
            pulse_rate(2, m, b, w);
            tm += m; tw += w;
        end
        check("t6_moves", tm, 15);
        check("t6_no_early_wrap", tw, 0);
        check("t6_cnt_max", int'(step_cnt), 15);
        r8 = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_move16", int'(move_tick), 1);
        @(negedge clk);
        check("t6_cnt_zero", int'(step_cnt), 0);
        check("t6_wrap_high", int'(step_wrap), 1);
        @(negedge clk);
        check("t6_wrap_low", int'(step_wrap), 0);
        r8 = 1'b0;
        repeat (4) @(negedge clk);

        // Random traffic, including occasional mid-game resets
        repeat (4000) begin
            if ($urandom_range(0, 7) == 0) r2 = ~r2;
            if ($urandom_range(0, 5) == 0) r4 = ~r4;
            if ($urandom_range(0, 3) == 0) r8 = ~r8;
            if ($urandom_range(0, 63) == 0) speed_sel = 2'($urandom_range(0, 3));
            start     = ($urandom_range(0, 39) == 0);
            pause     = ($urandom_range(0, 59) == 0);
            game_over = ($urandom_range(0, 79) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        start = 1'b0; pause = 1'b0; game_over = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    int m_order [5] = '{0, 1, 2, 0, 2};

endmodule
